wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Parametrised writeback stage: selects and aligns the main pipeline's result, and merges completions from long-latency side units (multiplier, divider) onto the single register-file write port through a valid/ready handshake. Load extraction uses the byte offset and funct3 rather than byte enables, and supports XLEN 32 or 64. A starvation counter forces a one-cycle main-pipeline stall when a side unit has waited too long. The block sits at the end of the pipeline and drives the regfile write port and the forwarding path.

## Interface
- XLEN, 32, datapath width; legal values 32, 64
- NUM_SIDE, 2, number of side completion channels, 1..8
- STARVE_LIMIT, 4, cycles a side channel may wait before a stall is forced, 1..15
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pipe_valid  in  1  main pipeline result present this cycle
- pipe_load_regfile  in  1  main result writes the regfile
- pipe_rd  in  5  main destination register
- pipe_sel  in  3  result kind: 0 alu, 1 br_en, 2 u_imm, 3 pc_plus4, 4 load; 5-7 illegal
- pipe_funct3  in  3  load size/sign: 0 lb, 1 lh, 2 lw, 3 ld (XLEN=64 only), 4 lbu, 5 lhu, 6 lwu (XLEN=64 only)
- pipe_addr_lo  in  log2(XLEN/8)  load byte offset
- pipe_alu, pipe_u_imm, pipe_pc, pipe_mem_rdata  in  XLEN each  candidate operands
- pipe_br_en  in  1  compare result
- side_valid  in  NUM_SIDE  side result present
- side_rd  in  5*NUM_SIDE  side destinations, channel i at [5i+4:5i]
- side_data  in  XLEN*NUM_SIDE  side results
- side_ready  out  NUM_SIDE  side result accepted this cycle (one-hot or zero)
- stall_o  out  1  main pipeline must hold; pipe_valid ignored this cycle
- load_regfile  out  1  registered regfile write enable
- rd_reg  out  5  registered write address
- regfilemux_o  out  XLEN  registered write data

## Operation
- Main result: pipe_sel picks alu, zero-extended br_en, u_imm, pc+4 (XLEN-wide add, wraps), or the aligned load.
- Load alignment: extract size-bytes at byte offset pipe_addr_lo from pipe_mem_rdata; sign- or zero-extend per funct3. A misaligned offset (not a multiple of the size) uses offset rounded down to size alignment. Illegal funct3 or illegal pipe_sel: write data 0 and a simulation-only fatal message.
- Arbitration per cycle, in priority order:
  - stall_o=1: grant the oldest-starved side channel (round-robin among those at the limit).
  - pipe_valid=1 and stall_o=0: main wins; no side_ready.
  - Otherwise: round-robin among asserted side_valid, starting after the last granted channel.
- Grant to side channel i: side_ready[i]=1 combinationally; the write uses side_rd[i] and side_data[i]. Producers hold valid/rd/data stable until ready.
- Write to rd=0, or main with pipe_load_regfile=0: load_regfile=0 next cycle. Side grants still consume the side result.
- Starve counters, one per side channel, saturating at STARVE_LIMIT: increment when valid and not granted; clear when granted or not valid.
- stall_o is registered: set next cycle if any counter equals STARVE_LIMIT and that channel is not granted this cycle; held high for exactly one cycle per forced grant.

## Timing
- Reset: load_regfile=0, rd_reg=0, regfilemux_o=0, stall_o=0, all counters 0, round-robin pointer at channel 0; side_ready=0 while rst=1.
- Latency: one cycle from the accepted input to the registered regfile outputs. Side handshake completes in the cycle where valid&ready.
- Reset asserted mid-stall clears stall_o and the counters in the same edge. A side result pending across reset is re-arbitrated afterwards, since the producer still holds it.
- Simultaneous stall and pipe_valid: the main result is not written; upstream re-presents it next cycle.
- Two channels at the limit in the same cycle: one forced grant per stall cycle, round-robin order; stall_o may stay high on consecutive cycles.

## Test plan
- Reset, then main alu=0x1234, rd=5 -> next cycle load_regfile=1, rd_reg=5, regfilemux_o=0x00001234.
- XLEN=32 lb, addr_lo=2, rdata=0x0080FF00 -> 0xFFFFFF80; lhu, addr_lo=2 -> 0x00000080; lh, addr_lo=3 -> treated as offset 2 -> 0x00000080.
- XLEN=64 lwu, addr_lo=4, rdata=0x80000001_00000000 -> 0x0000000080000001; ld -> full word.
- Side ch0 and ch1 valid, no main -> grants alternate ch0, ch1 on consecutive cycles; each result is written with its own rd.
- Main valid every cycle, side ch1 valid, STARVE_LIMIT=4 -> stall_o=1 for one cycle after 4 waiting cycles; side_ready[1]=1 in that cycle; the side data is written next cycle; the main result is not written that cycle.
- Main write to rd=0 -> load_regfile stays 0. Reset during stall_o=1 -> stall_o=0 and counters cleared the next cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage and regfile write-port arbiter.
//
// Selects and aligns the main pipeline result and merges it with completions
// from long-latency side units (multiplier, divider, ...) onto the single
// regfile write port. Side results use a valid/ready handshake. A per-channel
// starvation counter forces a one-cycle main-pipeline stall so that a side unit
// cannot be locked out by a continuously busy main pipeline.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pipe_*              main pipeline result, operands and load info
//   side_valid/rd/data  side completion channels (channel i in slice i)
//   side_ready          combinational grant to a side channel (one-hot or zero)
//   stall_o             registered; main pipeline must hold this cycle
//   load_regfile        registered regfile write enable
//   rd_reg              registered write address
//   regfilemux_o        registered write data
module wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_SIDE     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_valid,
    input  logic                      pipe_load_regfile,
    input  logic [4:0]                pipe_rd,
    input  logic [2:0]                pipe_sel,
    input  logic [2:0]                pipe_funct3,
    input  logic [$clog2(XLEN/8)-1:0] pipe_addr_lo,
    input  logic [XLEN-1:0]           pipe_alu,
    input  logic [XLEN-1:0]           pipe_u_imm,
    input  logic [XLEN-1:0]           pipe_pc,
    input  logic [XLEN-1:0]           pipe_mem_rdata,
    input  logic                      pipe_br_en,
    input  logic [NUM_SIDE-1:0]       side_valid,
    input  logic [5*NUM_SIDE-1:0]     side_rd,
    input  logic [XLEN*NUM_SIDE-1:0]  side_data,
    output logic [NUM_SIDE-1:0]       side_ready,
    output logic                      stall_o,
    output logic                      load_regfile,
    output logic [4:0]                rd_reg,
    output logic [XLEN-1:0]           regfilemux_o
);

    localparam int unsigned OffW  = $clog2(XLEN/8);
    localparam int unsigned IdxW  = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1;
    localparam logic [3:0]  Limit = 4'(STARVE_LIMIT);

    // State
    logic                     r_stall;
    logic [IdxW-1:0]          r_ptr;      // first channel to consider next
    logic [NUM_SIDE-1:0][3:0] r_starve;
    logic                     r_we;
    logic [4:0]               r_rd;
    logic [XLEN-1:0]          r_data;

    // Load alignment / main result
    logic [OffW-1:0] w_off;
    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_load;
    logic            w_load_bad;
    logic [XLEN-1:0] w_main_data;
    logic            w_main_bad;

    // Arbitration
    logic [NUM_SIDE-1:0]      w_at_limit;
    logic [NUM_SIDE-1:0]      w_cand;
    logic                     w_main_take;
    logic                     w_grant_any;
    logic [IdxW-1:0]          w_grant_idx;
    int unsigned              w_j;
    logic [IdxW-1:0]          w_ptr_d;
    logic [NUM_SIDE-1:0][3:0] w_starve_d;
    logic                     w_stall_d;
    logic                     w_take;
    logic                     w_we;
    logic [4:0]               w_rd;
    logic [XLEN-1:0]          w_data;

    always_comb begin
        // Misaligned offsets round down to the access size.
        w_off      = pipe_addr_lo & ~OffW'((32'd1 << pipe_funct3[1:0]) - 32'd1);
        w_sh       = pipe_mem_rdata >> {w_off, 3'b000};
        w_load     = '0;
        w_load_bad = 1'b0;
        case (pipe_funct3)
            3'd0: w_load = XLEN'($signed(w_sh[7:0]));
            3'd1: w_load = XLEN'($signed(w_sh[15:0]));
            3'd2: w_load = XLEN'($signed(w_sh[31:0]));
            3'd3: begin
                if (XLEN == 64) w_load = w_sh;
                else            w_load_bad = 1'b1;
            end
            3'd4: w_load = XLEN'(w_sh[7:0]);
            3'd5: w_load = XLEN'(w_sh[15:0]);
            3'd6: begin
                if (XLEN == 64) w_load = XLEN'(w_sh[31:0]);
                else            w_load_bad = 1'b1;
            end
            default: w_load_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_main_data = '0;
        w_main_bad  = 1'b0;
        case (pipe_sel)
            3'd0: w_main_data = pipe_alu;
            3'd1: w_main_data = XLEN'(pipe_br_en);
            3'd2: w_main_data = pipe_u_imm;
            3'd3: w_main_data = pipe_pc + XLEN'(4);
            3'd4: begin
                w_main_data = w_load_bad ? '0 : w_load;
                w_main_bad  = w_load_bad;
            end
            default: w_main_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_at_limit = '0;
        for (int i = 0; i < NUM_SIDE; i++) begin
            w_at_limit[i] = side_valid[i] && (r_starve[i] == Limit);
        end

        // A forced stall cycle only serves starved channels; otherwise main wins.
        w_main_take = pipe_valid && !r_stall && !rst;
        if (r_stall)         w_cand = w_at_limit;
        else if (pipe_valid) w_cand = '0;
        else                 w_cand = side_valid;

        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_j         = 0;
        for (int unsigned k = 0; k < NUM_SIDE; k++) begin
            w_j = (32'(r_ptr) + k) % NUM_SIDE;
            if (!w_grant_any && w_cand[IdxW'(w_j)]) begin
                w_grant_any = 1'b1;
                w_grant_idx = IdxW'(w_j);
            end
        end
        if (rst) w_grant_any = 1'b0;

        side_ready = '0;
        if (w_grant_any) side_ready[w_grant_idx] = 1'b1;

        w_ptr_d = r_ptr;
        if (w_grant_any) begin
            if (32'(w_grant_idx) == NUM_SIDE - 1) w_ptr_d = '0;
            else                                  w_ptr_d = w_grant_idx + IdxW'(1);
        end

        for (int i = 0; i < NUM_SIDE; i++) begin
            if (!side_valid[i] || side_ready[i]) w_starve_d[i] = '0;
            else if (r_starve[i] != Limit)       w_starve_d[i] = r_starve[i] + 4'd1;
            else                                 w_starve_d[i] = r_starve[i];
        end
        w_stall_d = |(w_at_limit & ~side_ready);

        w_take = 1'b0;
        w_we   = 1'b0;
        w_rd   = '0;
        w_data = '0;
        if (w_grant_any) begin
            w_take = 1'b1;
            w_rd   = side_rd[5*32'(w_grant_idx) +: 5];
            w_data = side_data[XLEN*32'(w_grant_idx) +: XLEN];
            w_we   = (w_rd != 5'd0);
        end else if (w_main_take) begin
            w_take = 1'b1;
            w_rd   = pipe_rd;
            w_data = w_main_data;
            w_we   = pipe_load_regfile && (pipe_rd != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall  <= 1'b0;
            r_ptr    <= '0;
            r_starve <= '0;
            r_we     <= 1'b0;
            r_rd     <= '0;
            r_data   <= '0;
        end else begin
            r_stall  <= w_stall_d;
            r_ptr    <= w_ptr_d;
            r_starve <= w_starve_d;
            r_we     <= w_we;
            if (w_take) begin
                r_rd   <= w_rd;
                r_data <= w_data;
            end
        end
    end

    assign stall_o      = r_stall;
    assign load_regfile = r_we;
    assign rd_reg       = r_rd;
    assign regfilemux_o = r_data;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && w_main_take && w_main_bad) begin
            $fatal(1, "wb_arbiter: illegal pipe_sel %0d / funct3 %0d", pipe_sel, pipe_funct3);
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a 32-bit instance with two side channels and
// starvation limit 4, plus a 64-bit instance for the wide load formats.
module tb_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 32-bit instance
    logic        pv, plr, pbr;
    logic [4:0]  prd;
    logic [2:0]  psel, pf3;
    logic [1:0]  paddr;
    logic [31:0] palu, puimm, ppc, prdata;
    logic [1:0]  sv;
    logic [9:0]  srd;
    logic [63:0] sdata;
    logic [1:0]  sready;
    logic        stall, lrf;
    logic [4:0]  rdr;
    logic [31:0] rfm;

    // 64-bit instance
    logic        qpv, qplr, qbr;
    logic [4:0]  qrd;
    logic [2:0]  qsel, qf3;
    logic [2:0]  qaddr;
    logic [63:0] qalu, quimm, qpc, qrdata;
    logic [1:0]  qsv;
    logic [9:0]  qsrd;
    logic [127:0] qsdata;
    logic [1:0]  qsready;
    logic        qstall, qlrf;
    logic [4:0]  qrdr;
    logic [63:0] qrfm;

    wb_arbiter #(.XLEN(32), .NUM_SIDE(2), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pv), .pipe_load_regfile(plr), .pipe_rd(prd), .pipe_sel(psel),
        .pipe_funct3(pf3), .pipe_addr_lo(paddr), .pipe_alu(palu), .pipe_u_imm(puimm),
        .pipe_pc(ppc), .pipe_mem_rdata(prdata), .pipe_br_en(pbr),
        .side_valid(sv), .side_rd(srd), .side_data(sdata), .side_ready(sready),
        .stall_o(stall), .load_regfile(lrf), .rd_reg(rdr), .regfilemux_o(rfm)
    );

    wb_arbiter #(.XLEN(64), .NUM_SIDE(2), .STARVE_LIMIT(4)) u_dut64 (
        .clk(clk), .rst(rst),
        .pipe_valid(qpv), .pipe_load_regfile(qplr), .pipe_rd(qrd), .pipe_sel(qsel),
        .pipe_funct3(qf3), .pipe_addr_lo(qaddr), .pipe_alu(qalu), .pipe_u_imm(quimm),
        .pipe_pc(qpc), .pipe_mem_rdata(qrdata), .pipe_br_en(qbr),
        .side_valid(qsv), .side_rd(qsrd), .side_data(qsdata), .side_ready(qsready),
        .stall_o(qstall), .load_regfile(qlrf), .rd_reg(qrdr), .regfilemux_o(qrfm)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Main-pipeline load on the 32-bit instance; result visible after one edge.
    task automatic load32(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] exp,
                          input string tag);
        pv = 1'b1; plr = 1'b1; prd = 5'd1; psel = 3'd4; pf3 = f3; paddr = a;
        tick();
        chk(tag, rfm, exp);
    endtask

    task automatic load64(input logic [2:0] f3, input logic [2:0] a, input logic [63:0] exp,
                          input string tag);
        qpv = 1'b1; qplr = 1'b1; qrd = 5'd4; qsel = 3'd4; qf3 = f3; qaddr = a;
        tick();
        chk(tag, qrfm, exp);
        chk({tag, "_we"}, qlrf, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        pv = 0; plr = 0; pbr = 0; prd = 0; psel = 0; pf3 = 0; paddr = 0;
        palu = 0; puimm = 0; ppc = 0; prdata = 0; sv = 0; srd = 0; sdata = 0;
        qpv = 0; qplr = 0; qbr = 0; qrd = 0; qsel = 0; qf3 = 0; qaddr = 0;
        qalu = 0; quimm = 0; qpc = 0; qrdata = 0; qsv = 0; qsrd = 0; qsdata = 0;

        // Reset state
        tick(); tick();
        chk("rst_we", lrf, 1'b0);
        chk("rst_rd", rdr, 5'd0);
        chk("rst_data", rfm, 32'd0);
        chk("rst_stall", stall, 1'b0);
        sv = 2'b11;
        #1;
        chk("rst_ready", sready, 2'b00);
        sv = 2'b00;
        rst = 1'b0;

        // Main results, one cycle latency
        pv = 1; plr = 1; prd = 5'd5; psel = 3'd0; palu = 32'h1234;
        tick();
        chk("alu_we", lrf, 1'b1);
        chk("alu_rd", rdr, 5'd5);
        chk("alu_data", rfm, 32'h0000_1234);
        prd = 5'd6; psel = 3'd1; pbr = 1'b1;
        tick();
        chk("br_data", rfm, 32'd1);
        chk("br_rd", rdr, 5'd6);
        prd = 5'd7; psel = 3'd2; puimm = 32'hABCD_E000;
        tick();
        chk("uimm_data", rfm, 32'hABCD_E000);
        prd = 5'd8; psel = 3'd3; ppc = 32'hFFFF_FFFC;
        tick();
        chk("pc4_wrap", rfm, 32'd0);

        // Load alignment on 0x0080FF00
        prdata = 32'h0080_FF00;
        load32(3'd0, 2'd2, 32'hFFFF_FF80, "lb_2");
        load32(3'd5, 2'd2, 32'h0000_0080, "lhu_2");
        load32(3'd1, 2'd3, 32'h0000_0080, "lh_3mis");
        load32(3'd1, 2'd0, 32'hFFFF_FF00, "lh_0");
        load32(3'd4, 2'd1, 32'h0000_00FF, "lbu_1");
        load32(3'd2, 2'd1, 32'h0080_FF00, "lw_1mis");

        // Writes suppressed for rd=0 and for pipe_load_regfile=0
        psel = 3'd0; prd = 5'd0;
        tick();
        chk("rd0_we", lrf, 1'b0);
        prd = 5'd9; plr = 1'b0;
        tick();
        chk("nold_we", lrf, 1'b0);
        pv = 1'b0; plr = 1'b1;

        // Round-robin between two side channels, no main traffic
        sv = 2'b11; srd = {5'd11, 5'd10}; sdata = {32'hBBBB_0001, 32'hAAAA_0000};
        #1;
        chk("rr_g0", sready, 2'b01);
        tick();
        chk("rr_w0_rd", rdr, 5'd10);
        chk("rr_w0_data", rfm, 32'hAAAA_0000);
        chk("rr_g1", sready, 2'b10);
        tick();
        chk("rr_w1_rd", rdr, 5'd11);
        chk("rr_w1_data", rfm, 32'hBBBB_0001);
        chk("rr_w1_we", lrf, 1'b1);
        sv = 2'b00;

        // Starvation: main valid every cycle, ch1 waiting
        pv = 1; plr = 1; prd = 5'd3; psel = 3'd0; palu = 32'h55;
        sv = 2'b10; srd = {5'd12, 5'd0}; sdata = {32'hCAFE_0012, 32'h0};
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("sv_nostall", stall, 1'b0);
            chk("sv_noready", sready, 2'b00);
            tick();
            chk("sv_main_rd", rdr, 5'd3);
        end
        chk("sv_stall", stall, 1'b1);
        chk("sv_forced", sready, 2'b10);
        tick();
        chk("sv_side_rd", rdr, 5'd12);
        chk("sv_side_data", rfm, 32'hCAFE_0012);
        sv = 2'b00;
        #1;
        chk("sv_stall_done", stall, 1'b0);
        tick();
        chk("sv_main_again", rdr, 5'd3);
        chk("sv_main_data", rfm, 32'h55);

        // Reset during a forced stall
        sv = 2'b10;
        repeat (5) tick();
        chk("rs_stall", stall, 1'b1);
        rst = 1'b1;
        #1;
        chk("rs_ready", sready, 2'b00);
        tick();
        chk("rs_stall_clr", stall, 1'b0);
        chk("rs_we_clr", lrf, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rs_cnt_clr", stall, 1'b0);
            tick();
        end
        pv = 1'b0;
        #1;
        chk("rs_rearb", sready, 2'b10);
        tick();
        chk("rs_rearb_rd", rdr, 5'd12);
        chk("rs_rearb_data", rfm, 32'hCAFE_0012);
        sv = 2'b00;

        // Two channels reach the limit together: back-to-back forced grants
        pv = 1; prd = 5'd3;
        sv = 2'b11; srd = {5'd11, 5'd10}; sdata = {32'hBBBB_0001, 32'hAAAA_0000};
        repeat (5) tick();
        chk("two_stall0", stall, 1'b1);
        chk("two_g0", sready, 2'b01);
        tick();
        chk("two_w0", rdr, 5'd10);
        sv = 2'b10;
        #1;
        chk("two_stall1", stall, 1'b1);
        chk("two_g1", sready, 2'b10);
        tick();
        chk("two_w1", rdr, 5'd11);
        sv = 2'b00;
        #1;
        chk("two_stall_end", stall, 1'b0);
        tick();
        chk("two_main", rdr, 5'd3);
        pv = 1'b0;

        // 64-bit load formats on 0x80000001_00000000
        qrdata = 64'h8000_0001_0000_0000;
        load64(3'd6, 3'd4, 64'h0000_0000_8000_0001, "lwu64_4");
        load64(3'd2, 3'd4, 64'hFFFF_FFFF_8000_0001, "lw64_4");
        load64(3'd3, 3'd0, 64'h8000_0001_0000_0000, "ld64_0");
        load64(3'd3, 3'd5, 64'h8000_0001_0000_0000, "ld64_5mis");
        load64(3'd0, 3'd7, 64'hFFFF_FFFF_FFFF_FF80, "lb64_7");
        qpv = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
